lcd_rgb_timing_gen: RTL and testbench

- Parallel-RGB LCD timing generator for the 800x480 5-inch panel, clocked by the PLL pixel clock (33 MHz from 27 MHz).
- Produces coordinate requests to an upstream pixel source and accepts that source's RGB data a fixed PIPE_LAT cycles later.
- Drives DE, HSYNC, VSYNC and RGB to the panel, with sync and DE delayed to align with the returned data.
- Provides a frame-aligned enable/disable state machine and frame/line strobes for downstream logic.

---
 rtl/lcd_rgb_timing_gen.sv | 148 ++++++++++++++
 tb/tb_lcd_rgb_timing_gen.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_rgb_timing_gen.sv
// Parallel-RGB LCD timing generator: frame-aligned start/stop, coordinate
// requests to a fixed-latency pixel source, and latency-matched panel outputs.
module lcd_rgb_timing_gen #(
    parameter int   H_ACTIVE = 800,
    parameter int   H_FP     = 40,
    parameter int   H_SYNC   = 48,
    parameter int   H_BP     = 88,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 13,
    parameter int   V_SYNC   = 3,
    parameter int   V_BP     = 32,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0,
    parameter int   PIPE_LAT = 2
) (
    input  logic        PixelClk,
    input  logic        nRST,
    input  logic        enable,
    output logic        req_valid,
    output logic [10:0] req_x,
    output logic [9:0]  req_y,
    input  logic [4:0]  pix_r,
    input  logic [5:0]  pix_g,
    input  logic [4:0]  pix_b,
    output logic        LCD_DE,
    output logic        LCD_HSYNC,
    output logic        LCD_VSYNC,
    output logic [4:0]  LCD_R,
    output logic [5:0]  LCD_G,
    output logic [4:0]  LCD_B,
    output logic        frame_start,
    output logic        line_start,
    output logic        running
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_ACT  = 11'(H_ACTIVE);
    localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
    localparam logic [10:0] HS_BEG = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0]  V_ACT  = 10'(V_ACTIVE);
    localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0]  VS_BEG = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]  VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [3:0]  D_LAST = 4'(PIPE_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_RUN,
        S_DRAIN
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [10:0]   h_cnt;
    logic [9:0]    v_cnt;
    logic          stop_pend;
    logic [3:0]    drain_cnt;
    logic          run;
    logic          h_last;
    logic          v_last;
    logic          hs_src;
    logic          vs_src;
    logic [PIPE_LAT-1:0] de_pipe;
    logic [PIPE_LAT-1:0] hs_pipe;
    logic [PIPE_LAT-1:0] vs_pipe;

    assign run    = (state_q == S_RUN);
    assign h_last = (h_cnt == H_LAST);
    assign v_last = (v_cnt == V_LAST);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (enable) state_d = S_START;
            S_START: state_d = S_RUN;
            S_RUN:   if (stop_pend && h_last && v_last) state_d = S_DRAIN;
            S_DRAIN: if (drain_cnt == D_LAST) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge PixelClk or negedge nRST) begin
        if (!nRST) begin
            state_q   <= S_IDLE;
            h_cnt     <= '0;
            v_cnt     <= '0;
            stop_pend <= 1'b0;
            drain_cnt <= '0;
        end else begin
            state_q   <= state_d;
            stop_pend <= run & ~enable;
            drain_cnt <= (state_q == S_DRAIN) ? drain_cnt + 4'd1 : 4'd0;
            if (!run) begin
                h_cnt <= '0;
                v_cnt <= '0;
            end else if (h_last) begin
                h_cnt <= '0;
                v_cnt <= v_last ? 10'd0 : v_cnt + 10'd1;
            end else begin
                h_cnt <= h_cnt + 11'd1;
            end
        end
    end

    assign req_valid   = run && (h_cnt < H_ACT) && (v_cnt < V_ACT);
    assign req_x       = req_valid ? h_cnt : 11'd0;
    assign req_y       = req_valid ? v_cnt : 10'd0;
    assign hs_src      = run && (h_cnt >= HS_BEG) && (h_cnt < HS_END);
    assign vs_src      = run && (v_cnt >= VS_BEG) && (v_cnt < VS_END);
    assign frame_start = run && (h_cnt == 11'd0) && (v_cnt == 10'd0);
    assign line_start  = run && (h_cnt == 11'd0);
    assign running     = run;

    // Timing flags ride alongside the source's return latency
    always_ff @(posedge PixelClk or negedge nRST) begin
        if (!nRST) begin
            de_pipe   <= '0;
            hs_pipe   <= '0;
            vs_pipe   <= '0;
            LCD_DE    <= 1'b0;
            LCD_HSYNC <= ~HS_POL;
            LCD_VSYNC <= ~VS_POL;
            LCD_R     <= '0;
            LCD_G     <= '0;
            LCD_B     <= '0;
        end else begin
            de_pipe[0] <= req_valid;
            hs_pipe[0] <= hs_src;
            vs_pipe[0] <= vs_src;
            for (int i = 1; i < PIPE_LAT; i++) begin
                de_pipe[i] <= de_pipe[i-1];
                hs_pipe[i] <= hs_pipe[i-1];
                vs_pipe[i] <= vs_pipe[i-1];
            end
            LCD_DE    <= de_pipe[PIPE_LAT-1];
            LCD_HSYNC <= hs_pipe[PIPE_LAT-1] ? HS_POL : ~HS_POL;
            LCD_VSYNC <= vs_pipe[PIPE_LAT-1] ? VS_POL : ~VS_POL;
            LCD_R     <= de_pipe[PIPE_LAT-1] ? pix_r : 5'd0;
            LCD_G     <= de_pipe[PIPE_LAT-1] ? pix_g : 6'd0;
            LCD_B     <= de_pipe[PIPE_LAT-1] ? pix_b : 5'd0;
        end
    end

endmodule

// File: tb/tb_lcd_rgb_timing_gen.sv
// Bench for lcd_rgb_timing_gen on a reduced 15x8 geometry so that several
// whole frames, stops, restarts and a mid-line reset fit in a short run.
module tb_lcd_rgb_timing_gen;

    localparam int HA = 8;
    localparam int HF = 2;
    localparam int HS = 3;
    localparam int HB = 2;
    localparam int VA = 4;
    localparam int VF = 1;
    localparam int VS = 2;
    localparam int VB = 1;
    localparam int LAT = 2;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FT = HT * VT;
    localparam int BIG = 1 << 30;

    // Run schedule, cycle numbers counted from reset release
    localparam int S0 = 7;
    localparam int DA = S0 + 2 * FT + HT + 3;
    localparam int EA = S0 + 3 * FT - 1;
    localparam int RB = EA + 15;
    localparam int S1 = RB + 2;
    localparam int GL = S1 + 30;
    localparam int GH = S1 + 40;
    localparam int DB = S1 + FT + 10;
    localparam int EB = S1 + 2 * FT - 1;
    localparam int S2 = EB + 5;
    localparam int RST_C = S2 + 20;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        req_valid;
    logic [10:0] req_x;
    logic [9:0]  req_y;
    logic [4:0]  pix_r;
    logic [5:0]  pix_g;
    logic [4:0]  pix_b;
    logic        LCD_DE;
    logic        LCD_HSYNC;
    logic        LCD_VSYNC;
    logic [4:0]  LCD_R;
    logic [5:0]  LCD_G;
    logic [4:0]  LCD_B;
    logic        frame_start;
    logic        line_start;
    logic        running;
    logic [15:0] src1;
    logic [15:0] src2;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int rs[$];
    int re[$];

    always #5 clk = ~clk;

    lcd_rgb_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HS_POL(1'b0), .VS_POL(1'b0), .PIPE_LAT(LAT)
    ) dut (
        .PixelClk(clk), .nRST(rst_n), .enable(en),
        .req_valid(req_valid), .req_x(req_x), .req_y(req_y),
        .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
        .LCD_DE(LCD_DE), .LCD_HSYNC(LCD_HSYNC), .LCD_VSYNC(LCD_VSYNC),
        .LCD_R(LCD_R), .LCD_G(LCD_G), .LCD_B(LCD_B),
        .frame_start(frame_start), .line_start(line_start),
        .running(running)
    );

    function automatic logic [15:0] pix_f(int x, int y);
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
        r = 5'(x + y);
        g = 6'(3 * x + y + 7);
        b = 5'(x + 2 * y + 1);
        return {r, g, b};
    endfunction

    // Upstream source: two-cycle return, garbage outside requests
    always @(posedge clk) begin
        src1 <= req_valid ? pix_f(int'(req_x), int'(req_y)) : 16'hFFFF;
        src2 <= src1;
    end
    assign {pix_r, pix_g, pix_b} = src2;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%0d required=%0d",
                     name, cyc, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic raw_at(input int c, output bit act, output bit de,
                          output bit hs, output bit vs,
                          output int h, output int v);
        act = 0; de = 0; hs = 0; vs = 0; h = 0; v = 0;
        foreach (rs[i]) begin
            if (c >= rs[i] && c <= re[i]) begin
                int p;
                p = (c - rs[i]) % FT;
                act = 1;
                h = p % HT;
                v = p / HT;
                de = (h < HA) && (v < VA);
                hs = (h >= HA + HF) && (h < HA + HF + HS);
                vs = (v >= VA + VF) && (v < VA + VF + VS);
            end
        end
    endtask

    task automatic check_cycle();
        bit a, d, hsy, vsy;
        int h, v;
        logic [15:0] erg;
        raw_at(cyc, a, d, hsy, vsy, h, v);
        chk("running", 32'(running), 32'(a));
        chk("req_valid", 32'(req_valid), 32'(d));
        chk("req_x", 32'(req_x), d ? 32'(h) : 32'd0);
        chk("req_y", 32'(req_y), d ? 32'(v) : 32'd0);
        chk("frame_start", 32'(frame_start), 32'(a && h == 0 && v == 0));
        chk("line_start", 32'(line_start), 32'(a && h == 0));
        raw_at(cyc - LAT - 1, a, d, hsy, vsy, h, v);
        erg = d ? pix_f(h, v) : 16'h0;
        chk("lcd_de", 32'(LCD_DE), 32'(d));
        chk("lcd_hsync", 32'(LCD_HSYNC), 32'(!hsy));
        chk("lcd_vsync", 32'(LCD_VSYNC), 32'(!vsy));
        chk("lcd_rgb", 32'({LCD_R, LCD_G, LCD_B}), 32'(erg));
    endtask

    function automatic bit en_sched(int c);
        if (c < DA) return 1'b1;
        if (c < RB) return 1'b0;
        if (c >= GL && c < GH) return 1'b0;
        if (c >= DB && c <= EB) return 1'b0;
        return 1'b1;
    endfunction

    typedef struct {
        bit          en;
        bit          run;
        bit          rv;
        int          x;
        bit          fs;
        bit          ls;
        bit          de;
        bit          hs;
        bit          vs;
        logic [15:0] rgb;
    } vec_t;

    vec_t tbl[12];

    initial begin
        int de_cnt = 0;
        int hs_lo = 0;
        int vs_lo = 0;
        int first_hs = -1;
        int first_vs = -1;
        int fs2 = -1;
        int ls2 = -1;

        for (int i = 0; i < 12; i++) begin
            tbl[i] = '{en: (i >= 5), run: 0, rv: 0, x: 0, fs: 0, ls: 0,
                       de: 0, hs: 1, vs: 1, rgb: 16'h0};
            if (i >= 7) begin
                tbl[i].run = 1;
                tbl[i].rv = 1;
                tbl[i].x = i - 7;
            end
        end
        tbl[7].fs = 1;
        tbl[7].ls = 1;
        tbl[10].de = 1;
        tbl[10].rgb = pix_f(0, 0);
        tbl[11].de = 1;
        tbl[11].rgb = pix_f(1, 0);

        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc = 0;

        for (int i = 0; i < 12; i++) begin
            if (i > 0) step();
            en = tbl[i].en;
            #1;
            chk($sformatf("t%0d_running", i), 32'(running), 32'(tbl[i].run));
            chk($sformatf("t%0d_req_valid", i), 32'(req_valid), 32'(tbl[i].rv));
            chk($sformatf("t%0d_req_x", i), 32'(req_x), 32'(tbl[i].x));
            chk($sformatf("t%0d_req_y", i), 32'(req_y), 32'd0);
            chk($sformatf("t%0d_fs", i), 32'(frame_start), 32'(tbl[i].fs));
            chk($sformatf("t%0d_ls", i), 32'(line_start), 32'(tbl[i].ls));
            chk($sformatf("t%0d_de", i), 32'(LCD_DE), 32'(tbl[i].de));
            chk($sformatf("t%0d_hs", i), 32'(LCD_HSYNC), 32'(tbl[i].hs));
            chk($sformatf("t%0d_vs", i), 32'(LCD_VSYNC), 32'(tbl[i].vs));
            chk($sformatf("t%0d_rgb", i), 32'({LCD_R, LCD_G, LCD_B}),
                32'(tbl[i].rgb));
        end

        rs = '{S0, S1, S2};
        re = '{EA, EB, BIG};

        // Two stops (one with a glitch that must not stop), restart in DRAIN
        while (cyc < RST_C - 1) begin
            step();
            en = en_sched(cyc);
            #1;
            check_cycle();
            if (cyc >= 12 && cyc <= 12 + FT - 1) begin
                de_cnt += int'(LCD_DE);
                hs_lo += int'(!LCD_HSYNC);
                vs_lo += int'(!LCD_VSYNC);
            end
            if (first_hs < 0 && !LCD_HSYNC) first_hs = cyc;
            if (first_vs < 0 && !LCD_VSYNC) first_vs = cyc;
            if (fs2 < 0 && frame_start) fs2 = cyc;
            if (ls2 < 0 && line_start && !frame_start) ls2 = cyc;
        end
        chk("frame_de_cycles", 32'(de_cnt), 32'd32);
        chk("frame_hsync_low", 32'(hs_lo), 32'd24);
        chk("frame_vsync_low", 32'(vs_lo), 32'd30);
        chk("first_hsync_low", 32'(first_hs), 32'd20);
        chk("first_vsync_low", 32'(first_vs), 32'd85);
        chk("second_frame_start", 32'(fs2), 32'd127);
        chk("second_line_start", 32'(ls2), 32'd22);

        // Reset in the middle of an active line
        step();
        en = 1'b1;
        #1;
        check_cycle();
        chk("pre_rst_de", 32'(LCD_DE), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_running", 32'(running), 32'd0);
        chk("rst_req_valid", 32'(req_valid), 32'd0);
        chk("rst_req_xy", 32'({req_x, req_y}), 32'd0);
        chk("rst_strobes", 32'({frame_start, line_start}), 32'd0);
        chk("rst_de", 32'(LCD_DE), 32'd0);
        chk("rst_hsync", 32'(LCD_HSYNC), 32'd1);
        chk("rst_vsync", 32'(LCD_VSYNC), 32'd1);
        chk("rst_rgb", 32'({LCD_R, LCD_G, LCD_B}), 32'd0);
        step();
        step();
        rst_n = 1'b1;
        cyc = 0;
        rs.delete();
        re.delete();
        rs.push_back(2);
        re.push_back(BIG);
        #1;
        check_cycle();
        while (cyc < 40) begin
            step();
            #1;
            check_cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
